// File: rtl/arith_pipe_unit.sv
// Two-stage add/subtract/accumulate pipeline with valid/ready handshakes on both sides.
// Optional signed saturation on overflow is enabled by defining ARITH_SAT_EN.
module arith_pipe_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [2:0]       sel_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] d_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             neg_o
);

`ifdef ARITH_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {WIDTH{1'b1}} >> 1;
    localparam logic [WIDTH-1:0] SAT_MIN = ~SAT_MAX;
`endif

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic             s1_cin_r;
    logic [2:0]       s1_sel_r;
    logic [WIDTH-1:0] acc_r;

    logic             s2_advance_s;
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_y_s;
    logic [WIDTH:0]   sum_s;
    logic             carry_msb_s;
    logic             ovf_s;
    logic [WIDTH-1:0] res_s;

    // Handshake: S2 drains when empty or the consumer takes it; S1 refills behind it.
    always_comb begin
        s2_advance_s = !valid_o || ready_i;
        ready_o      = !s1_valid_r || s2_advance_s;
    end

    // Operand selection and the adder; carry into the MSB is recovered from the sum bit.
    always_comb begin
        op_a_s = s1_sel_r[2] ? acc_r : s1_a_r;
        case (s1_sel_r[1:0])
            2'b00:   op_y_s = s1_b_r;
            2'b01:   op_y_s = ~s1_b_r;
            2'b10:   op_y_s = {WIDTH{1'b0}};
            2'b11:   op_y_s = {WIDTH{1'b1}};
            default: op_y_s = s1_b_r;
        endcase
        sum_s       = {1'b0, op_a_s} + {1'b0, op_y_s} + {{WIDTH{1'b0}}, s1_cin_r};
        carry_msb_s = op_a_s[WIDTH-1] ^ op_y_s[WIDTH-1] ^ sum_s[WIDTH-1];
        ovf_s       = carry_msb_s ^ sum_s[WIDTH];
    end

    // Final result, clamped toward the sign of A' when saturation is built in.
    always_comb begin
`ifdef ARITH_SAT_EN
        if (ovf_s) begin
            res_s = op_a_s[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end else begin
            res_s = sum_s[WIDTH-1:0];
        end
`else
        res_s = sum_s[WIDTH-1:0];
`endif
    end

    // Stage 1: capture the operands of an accepted transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_cin_r   <= 1'b0;
            s1_sel_r   <= 3'b000;
        end else if (ready_o) begin
            s1_valid_r <= valid_i;
            if (valid_i) begin
                s1_a_r   <= a_i;
                s1_b_r   <= b_i;
                s1_cin_r <= cin_i;
                s1_sel_r <= sel_i;
            end
        end
    end

    // Stage 2 and accumulator: both load on the edge an op leaves S1, so a following
    // accumulate op in S1 sees this result without any bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            d_o     <= {WIDTH{1'b0}};
            cout_o  <= 1'b0;
            ovf_o   <= 1'b0;
            zero_o  <= 1'b0;
            neg_o   <= 1'b0;
            acc_r   <= {WIDTH{1'b0}};
        end else if (s2_advance_s) begin
            valid_o <= s1_valid_r;
            if (s1_valid_r) begin
                d_o    <= res_s;
                cout_o <= sum_s[WIDTH];
                ovf_o  <= ovf_s;
                zero_o <= (res_s == {WIDTH{1'b0}});
                neg_o  <= res_s[WIDTH-1];
                acc_r  <= res_s;
            end
        end
    end

endmodule

// File: tb/tb_arith_pipe_unit.sv
// Scoreboard bench for arith_pipe_unit (WIDTH=8): directed scenarios plus randomized
// traffic, expected results from an integer-arithmetic reference model.
module tb_arith_pipe_unit;

    logic       clk = 1'b0;
    logic       rst_i, cin_i, valid_i, ready_i;
    logic [7:0] a_i, b_i;
    logic [2:0] sel_i;
    logic       ready_o, valid_o, cout_o, ovf_o, zero_o, neg_o;
    logic [7:0] d_o;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic       rand_rdy = 1'b0;
    logic [11:0] exp_q[$];
    logic [7:0] model_acc = 8'h00;

    arith_pipe_unit #(.WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .sel_i(sel_i),
        .valid_i(valid_i), .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i),
        .d_o(d_o), .cout_o(cout_o), .ovf_o(ovf_o), .zero_o(zero_o), .neg_o(neg_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain unsigned and signed integer sums; returns {d, cout, ovf, zero, neg}.
    function automatic logic [11:0] model_op(input logic [7:0] a, input logic [7:0] b,
                                             input logic cin, input logic [2:0] sel,
                                             input logic [7:0] acc);
        int ua, uy, us, sa, sy, ss, d;
        logic ovf;
        ua = sel[2] ? int'(acc) : int'(a);
        case (sel[1:0])
            2'b00:   uy = int'(b);
            2'b01:   uy = 255 - int'(b);
            2'b10:   uy = 0;
            default: uy = 255;
        endcase
        us  = ua + uy + int'(cin);
        sa  = (ua > 127) ? ua - 256 : ua;
        sy  = (uy > 127) ? uy - 256 : uy;
        ss  = sa + sy + int'(cin);
        ovf = (ss > 127) || (ss < -128);
        d   = us % 256;
`ifdef ARITH_SAT_EN
        if (ovf) d = (sa >= 0) ? 127 : 128;
`endif
        return {d[7:0], (us > 255), ovf, (d == 0), (d >= 128)};
    endfunction

    // Input monitor: an accepted op pushes its expected response; reset flushes.
    always @(negedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            model_acc = 8'h00;
        end else if (valid_i && ready_o) begin
            logic [11:0] r;
            r = model_op(a_i, b_i, cin_i, sel_i, model_acc);
            exp_q.push_back(r);
            model_acc = r[11:4];
        end
    end

    // Output monitor: every delivered result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {20'h0, d_o, cout_o, ovf_o, zero_o, neg_o}, 32'hFFFF_FFFF);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                chk("result", {20'h0, d_o, cout_o, ovf_o, zero_o, neg_o}, {20'h0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) ready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            input logic [2:0] sel);
        logic ok = 1'b0;
        a_i = a; b_i = b; cin_i = cin; sel_i = sel; valid_i = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = ready_o;
            tick();
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        valid_i = 1'b0;
    endtask

    task automatic check_next(input string name, input logic [7:0] exp_d);
        logic seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (valid_o) begin
                seen = 1'b1;
                chk(name, {24'h0, d_o}, {24'h0, exp_d});
            end
            tick();
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drain();
        ready_i = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] held_d;
        logic [7:0] bp_a[3] = '{8'h11, 8'h22, 8'h33};
        int idx, nacc;
        logic ok;
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; cin_i = 1'b0;
        a_i = 8'h00; b_i = 8'h00; sel_i = 3'b000;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_ready_o", ready_o, 32'd1);
        chk("rst_valid_o", valid_o, 32'd0);
        chk("rst_outputs", {d_o, cout_o, ovf_o, zero_o, neg_o}, 32'd0);
        tick();

        // Plain add with latency check.
        drive_op(8'h05, 8'h03, 1'b0, 3'b000);
        @(negedge clk);
        chk("latency_c1_valid", valid_o, 32'd0);
        tick();
        @(negedge clk);
        chk("latency_c2_valid", valid_o, 32'd1);
        chk("add_d", d_o, 32'h08);
        chk("add_flags", {cout_o, ovf_o, zero_o}, 32'd0);
        tick();

        drive_op(8'h10, 8'h10, 1'b1, 3'b001);
        check_next("sub_zero_d", 8'h00);
        drive_op(8'h7F, 8'h01, 1'b0, 3'b000);
`ifdef ARITH_SAT_EN
        check_next("ovf_d", 8'h7F);
`else
        check_next("ovf_d", 8'h80);
`endif

        // Back-to-back accumulate chain: 0x05, 0x09, 0x0A.
        drive_op(8'h02, 8'h03, 1'b0, 3'b000);
        drive_op(8'h00, 8'h04, 1'b0, 3'b100);
        drive_op(8'h00, 8'h00, 1'b1, 3'b110);
        drain();

        // Backpressure: three ops offered while the consumer stalls for four cycles.
        ready_i = 1'b0; idx = 0; nacc = 0; held_d = 8'h00;
        for (int cyc = 0; cyc < 4; cyc++) begin
            a_i = bp_a[idx]; b_i = 8'h01; cin_i = 1'b0; sel_i = 3'b000; valid_i = 1'b1;
            @(negedge clk);
            ok = ready_o;
            if (cyc == 2) held_d = d_o;
            if (cyc == 3) begin
                chk("bp_ready_low", ready_o, 32'd0);
                chk("bp_accepted", nacc, 32'd2);
                chk("bp_d_stable", d_o, {24'h0, held_d});
                chk("bp_valid_held", valid_o, 32'd1);
            end
            tick();
            if (ok) begin idx++; nacc++; end
        end
        ready_i = 1'b1;
        drive_op(bp_a[2], 8'h01, 1'b0, 3'b000);
        drain();

        // Reset with two ops in flight and a valid_i offered during reset.
        ready_i = 1'b0;
        drive_op(8'h40, 8'h01, 1'b0, 3'b000);
        drive_op(8'h41, 8'h01, 1'b0, 3'b000);
        rst_i = 1'b1; valid_i = 1'b1; a_i = 8'h55; sel_i = 3'b000;
        tick();
        rst_i = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        chk("rst_flight_valid", valid_o, 32'd0);
        chk("rst_flight_ready", ready_o, 32'd1);
        tick();
        ready_i = 1'b1;
        drive_op(8'hAA, 8'h01, 1'b0, 3'b100);
        check_next("acc_after_rst", 8'h01);
        drain();

        // Randomized traffic with random gaps and random consumer stalls.
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            drive_op(8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom));
        end
        rand_rdy = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arith_pipe_unit.md
ARITH_PIPE_UNIT -- requirements
Module: arith_pipe_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 1..64).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports a_i, b_i  input  WIDTH  operands A and B.
REQ-005 SHALL have port cin_i  input  1  carry-in.
REQ-006 SHALL have port sel_i  input  3  [1:0] B-operand select, [2] accumulate (A replaced by accumulator).
REQ-007 SHALL have ports valid_i input 1 / ready_o output 1  upstream handshake.
REQ-008 SHALL have ports valid_o output 1 / ready_i input 1  downstream handshake.
REQ-009 SHALL have port d_o  output  WIDTH  result.
REQ-010 SHALL have ports cout_o, ovf_o, zero_o, neg_o  output  1 each  carry-out, signed overflow, result==0, result MSB.

Function
REQ-011 SHALL compute D = A' + Y + cin, modulo 2^WIDTH; Y: sel[1:0]=00 B, 01 ~B, 10 all-zeros, 11 all-ones.
REQ-012 SHALL take A' = a_i when sel[2]=0, A' = accumulator when sel[2]=1.
REQ-013 SHALL implement two stages: S1 registers a_i/b_i/cin_i/sel_i on accept; S2 registers D and flags computed from S1 contents.
REQ-014 SHALL accept a transfer when valid_i && ready_o; SHALL deliver when valid_o && ready_i.
REQ-015 SHALL drive ready_o = !S1_valid || S2_advance, where S2_advance = !S2_valid || ready_i (combinational from ready_i permitted).
REQ-016 SHALL have latency exactly 2 cycles from accept to valid_o with ready_i held high; throughput one op per cycle.
REQ-017 SHALL hold d_o and all flags stable while valid_o && !ready_i.
REQ-018 SHALL preserve order; no op dropped or duplicated under any valid/ready pattern.
REQ-019 SHALL update the accumulator with D on the same edge S1 moves into S2, so an accumulate op uses the result of the immediately preceding op without stalls.
REQ-020 SHALL set cout_o = carry out of bit WIDTH-1; ovf_o = carry into MSB XOR carry out of MSB.
REQ-021 SHALL set zero_o and neg_o from the final d_o value (after saturation if enabled).
REQ-022 SHALL, when S1 and S2 full and ready_i=0, deassert ready_o and ignore valid_i.
REQ-023 SHALL, with WIDTH=1, give ovf_o = cin XOR cout-equivalent per REQ-020 (carry into bit 0 = cin_i).

Reset
REQ-024 SHALL on rst_i=1 at a clock edge clear S1_valid, S2_valid, accumulator, d_o and all flags to 0.
REQ-025 SHALL discard in-flight ops when reset asserts mid-operation; valid_o=0 the cycle after reset edge.
REQ-026 SHALL drive ready_o=1 in the first cycle after rst_i deasserts.
REQ-027 SHALL ignore valid_i while rst_i=1.

Configuration
REQ-028 SHALL use macro ARITH_SAT_EN.
REQ-029 SHALL, with ARITH_SAT_EN defined, clamp D on signed overflow to max positive (0x7F..F) if A' MSB=0, else min negative (0x80..0); ovf_o still asserted; accumulator receives clamped value.
REQ-030 SHALL, without ARITH_SAT_EN, wrap modulo 2^WIDTH; no saturation logic present.

Verification (WIDTH=8)
REQ-031 SHALL cover add: A=0x05, B=0x03, sel=000, cin=0 -> 2 cycles later d_o=0x08, cout=0, ovf=0, zero=0.
REQ-032 SHALL cover subtract/zero: A=0x10, B=0x10, sel=001, cin=1 -> d_o=0x00, cout=1, zero=1, neg=0.
REQ-033 SHALL cover overflow: A=0x7F, B=0x01, sel=000, cin=0 -> wrap build d_o=0x80, ovf=1, neg=1; ARITH_SAT_EN build d_o=0x7F, ovf=1.
REQ-034 SHALL cover back-to-back accumulate: ops (A=0x02,B=0x03,000) then (B=0x04,100) then (B=0x00,110,cin=1) on consecutive cycles -> results 0x05, 0x09, 0x0A.
REQ-035 SHALL cover backpressure: ready_i=0 for 4 cycles while 3 ops offered -> ready_o low after 2 accepted, d_o stable; ready_i=1 -> all 3 results in order, none lost.
REQ-036 SHALL cover reset mid-flight: 2 ops in pipe, rst_i 1 cycle -> valid_o=0, accumulator=0, next accumulate op with B=0x01, sel=100, cin=0 -> d_o=0x01.
